// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencing controller: stall encodings,
// reset polarity, redirect defaults and the controller state type.
package pipe_ctrl_pkg;

   localparam int MC_LEN_W_DEFAULT = 6;

   typedef logic [5:0]                  stall_bus_t;
   typedef logic [MC_LEN_W_DEFAULT-1:0] mc_len_bus_t;

   localparam logic        RST_ENABLE = 1'b1;
   localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

   // Stall bit order: [0] pc, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB.
   localparam stall_bus_t STALL_NONE = 6'b000000;
   localparam stall_bus_t STALL_ID   = 6'b000111;
   localparam stall_bus_t STALL_EX   = 6'b001111;

   typedef enum logic {
      CTRL_RUN = 1'b0,
      CTRL_MC  = 1'b1
   } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: per-stage stall vector, multi-cycle EX
// sequencing with a down-counter, and exception flush with redirect PC.
// Owns no datapath state; drives the pipeline registers' stall/flush inputs.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MC_LEN_W = MC_LEN_W_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stallreq_id,
   input  logic                ex_mc_start,
   input  logic [MC_LEN_W-1:0] ex_mc_len,
   input  logic                flush_req,
   input  logic [31:0]         excpt_pc,
   output logic [5:0]          stall,
   output logic                flush,
   output logic [31:0]         new_pc,
   output logic                mc_busy,
   output logic                mc_done,
   output logic [31:0]         perf_stall_cnt
);

   ctrl_state_e         state_q;
   logic [MC_LEN_W-1:0] cnt_q;
   logic                mc_done_q;
   logic [31:0]         perf_cnt_q;
   logic [31:0]         perf_cnt_d;
   logic                accept;

   // A new multi-cycle op is taken only from RUN, never in its own
   // completion cycle (EX still holds ex_mc_start then), never under flush,
   // and only for a non-zero length (length 0 is an ordinary single-cycle op).
   always_comb begin
      accept = (state_q == CTRL_RUN) && ex_mc_start && !mc_done_q &&
               !flush_req && (ex_mc_len != '0);
   end

   // Stall/flush/redirect outputs by priority: flush, multi-cycle, load-use.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
      stall  = STALL_NONE;
      flush  = 1'b0;
      new_pc = ZERO_WORD;
      if (rst != RST_ENABLE) begin
         if (flush_req) begin
            flush  = 1'b1;
            new_pc = excpt_pc;
         end else if ((state_q == CTRL_MC) || accept) begin
            stall = STALL_EX;
         end else if (stallreq_id) begin
            stall = STALL_ID;
         end
      end
   end

   // Stall-cycle counter advances on every cycle the pc is held.
   always_comb begin
      perf_cnt_d = perf_cnt_q + 32'(stall[0]);
   end

   // Controller FSM: RUN/MC state, remaining-cycle counter and done pulse.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst == RST_ENABLE) begin
         state_q   <= CTRL_RUN;
         cnt_q     <= '0;
         mc_done_q <= 1'b0;
      end else if (flush_req) begin
         state_q   <= CTRL_RUN;
         cnt_q     <= '0;
         mc_done_q <= 1'b0;
      end else begin
         case (state_q)
            CTRL_RUN: begin
               if (accept && (ex_mc_len == MC_LEN_W'(1))) begin
                  mc_done_q <= 1'b1;
               end else if (accept) begin
                  state_q   <= CTRL_MC;
                  cnt_q     <= ex_mc_len - MC_LEN_W'(1);
                  mc_done_q <= 1'b0;
               end else begin
                  mc_done_q <= 1'b0;
               end
            end
            CTRL_MC: begin
               cnt_q <= cnt_q - MC_LEN_W'(1);
               if (cnt_q == MC_LEN_W'(1)) begin
                  state_q   <= CTRL_RUN;
                  mc_done_q <= 1'b1;
               end else begin
                  mc_done_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= CTRL_RUN;
               cnt_q     <= '0;
               mc_done_q <= 1'b0;
            end
         endcase
      end
   end

   // Performance counter of pc-stall cycles, wrapping modulo 2^32.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         perf_cnt_q <= '0;
      end else begin
         perf_cnt_q <= perf_cnt_d;
      end
   end

   assign mc_busy        = (state_q == CTRL_MC);
   assign mc_done        = mc_done_q;
   assign perf_stall_cnt = perf_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a cycle-level model tracking the number
// of remaining stall cycles of the current op, compared every cycle, plus
// hand-computed literal expectations at key points of each scenario.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stallreq_id = 1'b0;
   logic        ex_mc_start = 1'b0;
   logic [5:0]  ex_mc_len = 6'd0;
   logic        flush_req = 1'b0;
   logic [31:0] excpt_pc = 32'h0;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        mc_busy;
   logic        mc_done;
   logic [31:0] perf_stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: stall cycles still owed by the running op, pending done
   // pulse, and the stall-cycle total.
   int          m_rem  = 0;
   bit          m_done = 1'b0;
   logic [31:0] m_perf = 32'h0;

   pipe_ctrl #(.MC_LEN_W(6)) dut (
      .clk            (clk),
      .rst            (rst),
      .stallreq_id    (stallreq_id),
      .ex_mc_start    (ex_mc_start),
      .ex_mc_len      (ex_mc_len),
      .flush_req      (flush_req),
      .excpt_pc       (excpt_pc),
      .stall          (stall),
      .flush          (flush),
      .new_pc         (new_pc),
      .mc_busy        (mc_busy),
      .mc_done        (mc_done),
      .perf_stall_cnt (perf_stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   function automatic bit m_accept();
      return !rst && (m_rem == 0) && ex_mc_start && !m_done && !flush_req && (ex_mc_len != 6'd0);
   endfunction

   function automatic logic [5:0] m_stall();
      if (rst)                      return 6'b000000;
      if (flush_req)                return 6'b000000;
      if (m_rem > 0 || m_accept())  return 6'b001111;
      if (stallreq_id)              return 6'b000111;
      return 6'b000000;
   endfunction

   // Compare on the falling edge, advance the model on the rising edge.
   initial begin
      @(posedge clk);
      forever begin
         logic [5:0] s;
         bit         acc;
         @(negedge clk);
         check("stall",   32'(stall),          32'(m_stall()));
         check("flush",   32'(flush),          32'(!rst && flush_req));
         check("new_pc",  new_pc,              (!rst && flush_req) ? excpt_pc : 32'h0);
         check("mc_busy", 32'(mc_busy),        32'(m_rem > 0));
         check("mc_done", 32'(mc_done),        32'(m_done));
         check("perf",    perf_stall_cnt,      m_perf);
         @(posedge clk);
         s   = m_stall();
         acc = m_accept();
         if (rst) begin
            m_rem  = 0;
            m_done = 1'b0;
            m_perf = 32'h0;
         end else begin
            m_perf = m_perf + 32'(s[0]);
            if (flush_req) begin
               m_rem  = 0;
               m_done = 1'b0;
            end else if (m_rem > 0) begin
               m_rem  = m_rem - 1;
               m_done = (m_rem == 0);
            end else if (acc) begin
               m_rem  = int'(ex_mc_len) - 1;
               m_done = (ex_mc_len == 6'd1);
            end else begin
               m_done = 1'b0;
            end
         end
      end
   end

   // One cycle: drive inputs just after the rising edge, return just after
   // the falling edge so literal checks see settled outputs.
   task automatic cyc(input logic r, input logic sid, input logic st, input logic [5:0] len,
                      input logic fl, input logic [31:0] pc);
      @(posedge clk);
      #1;
      rst         = r;
      stallreq_id = sid;
      ex_mc_start = st;
      ex_mc_len   = len;
      flush_req   = fl;
      excpt_pc    = pc;
      @(negedge clk);
      #1;
   endtask

   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      // Reset with hazard and flush requests held: everything forced quiet.
      cyc(1, 1, 0, 0, 1, 32'hDEAD_BEEF);
      cyc(1, 1, 0, 0, 1, 32'hDEAD_BEEF);
      check("rst_stall",  32'(stall), 32'h0);
      check("rst_flush",  32'(flush), 32'h0);
      check("rst_new_pc", new_pc,     32'h0);
      check("rst_perf",   perf_stall_cnt, 32'h0);
      cyc(0, 0, 0, 0, 0, 32'h0);

      // N=5 divide, EX holds start through the done cycle.
      cyc(0, 0, 1, 6'd5, 0, 32'h0);
      check("n5_t0_stall", 32'(stall), 32'h0F);
      check("n5_t0_busy",  32'(mc_busy), 32'h0);
      cyc(0, 0, 1, 6'd5, 0, 32'h0);
      check("n5_t1_busy",  32'(mc_busy), 32'h1);
      cyc(0, 0, 1, 6'd5, 0, 32'h0);
      cyc(0, 0, 1, 6'd5, 0, 32'h0);
      cyc(0, 0, 1, 6'd5, 0, 32'h0);
      check("n5_t4_stall", 32'(stall), 32'h0F);
      check("n5_t4_done",  32'(mc_done), 32'h0);
      cyc(0, 0, 1, 6'd5, 0, 32'h0);
      check("n5_t5_done",  32'(mc_done), 32'h1);
      check("n5_t5_stall", 32'(stall), 32'h00);
      check("n5_t5_perf",  perf_stall_cnt, 32'd5);
      cyc(0, 0, 0, 6'd0, 0, 32'h0);
      check("n5_t6_done",  32'(mc_done), 32'h0);

      // N=1, with a load-use hazard in the done cycle while start is held.
      cyc(0, 0, 1, 6'd1, 0, 32'h0);
      check("n1_stall", 32'(stall), 32'h0F);
      cyc(0, 1, 1, 6'd1, 0, 32'h0);
      check("n1_done",       32'(mc_done), 32'h1);
      check("n1_done_stall", 32'(stall), 32'h07);
      cyc(0, 0, 0, 6'd0, 0, 32'h0);

      // N=0: single-cycle op, no stall and no done.
      cyc(0, 0, 1, 6'd0, 0, 32'h0);
      check("n0_stall", 32'(stall), 32'h0);
      cyc(0, 0, 1, 6'd0, 0, 32'h0);
      cyc(0, 0, 0, 6'd0, 0, 32'h0);
      check("n0_done", 32'(mc_done), 32'h0);

      // Load-use in RUN.
      cyc(0, 1, 0, 6'd0, 0, 32'h0);
      check("lu_stall", 32'(stall), 32'h07);

      // Flush mid-op: N=10 at T, exception at T+3.
      cyc(0, 0, 1, 6'd10, 0, 32'h0);
      cyc(0, 0, 1, 6'd10, 0, 32'h0);
      cyc(0, 0, 1, 6'd10, 0, 32'h0);
      cyc(0, 0, 1, 6'd10, 1, 32'h0000_0200);
      check("fl_flush",  32'(flush), 32'h1);
      check("fl_new_pc", new_pc,     32'h0000_0200);
      check("fl_stall",  32'(stall), 32'h0);
      cyc(0, 0, 0, 6'd0, 0, 32'h0);
      check("fl_busy", 32'(mc_busy), 32'h0);
      repeat (12) cyc(0, 0, 0, 6'd0, 0, 32'h0);

      // Flush in the done cycle wins; back-to-back reacceptance afterwards.
      cyc(0, 0, 1, 6'd2, 0, 32'h0);
      cyc(0, 0, 1, 6'd2, 0, 32'h0);
      cyc(0, 0, 1, 6'd2, 1, 32'h0000_0400);
      cyc(0, 0, 0, 6'd0, 0, 32'h0);
      check("fd_done", 32'(mc_done), 32'h0);
      cyc(0, 0, 1, 6'd2, 0, 32'h0);
      cyc(0, 0, 1, 6'd2, 0, 32'h0);
      cyc(0, 0, 0, 6'd3, 0, 32'h0);
      cyc(0, 0, 1, 6'd3, 0, 32'h0);

      // Load-use absorbed during MC.
      repeat (3) cyc(0, 1, 1, 6'd3, 0, 32'h0);
      cyc(0, 1, 1, 6'd3, 0, 32'h0);
      cyc(0, 0, 0, 6'd0, 0, 32'h0);

      // Reset mid-op aborts with no done pulse.
      cyc(0, 0, 1, 6'd6, 0, 32'h0);
      cyc(0, 0, 1, 6'd6, 0, 32'h0);
      cyc(1, 0, 1, 6'd6, 0, 32'h0);
      cyc(0, 0, 0, 6'd0, 0, 32'h0);
      repeat (6) cyc(0, 0, 0, 6'd0, 0, 32'h0);

      // Counter wrap: preload all-ones, then one stalled cycle.
      cyc(0, 1, 0, 6'd0, 0, 32'h0);
      force dut.perf_cnt_q = 32'hFFFF_FFFF;
      m_perf = 32'hFFFF_FFFF;
      #1;
      release dut.perf_cnt_q;
      cyc(0, 0, 0, 6'd0, 0, 32'h0);
      check("wrap_perf", perf_stall_cnt, 32'h0);
      cyc(0, 0, 0, 6'd0, 0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
